// File: rtl/button_debounce_pulse.sv
// Push-button conditioner: 2-flop synchroniser, press/release debounce FSM and a
// single-cycle count-enable pulse per accepted press, with optional auto-repeat while held.
module button_debounce_pulse #(
  parameter int unsigned DEB_CYCLES    = 1000000,
  parameter int unsigned REPEAT_EN     = 1,
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 20000000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       pulse,
  output logic       level,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StPressChk = 2'b01,
    StHeld     = 2'b10,
    StRelChk   = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] DebLast    = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DelayLast  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(REPEAT_PERIOD - 1);

  logic             s1_q, s2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             rpt_phase_q, rpt_phase_d;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] rpt_last;

  // First repeat waits the long delay; later repeats use the shorter period.
  assign rpt_last = rpt_phase_q ? PeriodLast : DelayLast;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rcnt_d      = rcnt_q;
    rpt_phase_d = rpt_phase_q;
    pulse_d     = 1'b0;
    level_d     = level_q;
    unique case (state_q)
      StIdle: begin
        if (s2_q) begin
          state_d = StPressChk;
          cnt_d   = '0;
        end
      end
      StPressChk: begin
        if (!s2_q) begin
          state_d = StIdle;
        end else if (cnt_q == DebLast) begin
          state_d     = StHeld;
          pulse_d     = 1'b1;
          level_d     = 1'b1;
          rcnt_d      = '0;
          rpt_phase_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHeld: begin
        if (!s2_q) begin
          state_d = StRelChk;
          cnt_d   = '0;
        end else if (REPEAT_EN != 0) begin
          if (rcnt_q == rpt_last) begin
            pulse_d     = 1'b1;
            rcnt_d      = '0;
            rpt_phase_d = 1'b1;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
      end
      StRelChk: begin
        // A release bounce returns to HELD and restarts repeat timing without a pulse.
        if (s2_q) begin
          state_d     = StHeld;
          rcnt_d      = '0;
          rpt_phase_d = 1'b0;
        end else if (cnt_q == DebLast) begin
          state_d = StIdle;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      rcnt_q      <= '0;
      rpt_phase_q <= 1'b0;
      pulse_q     <= 1'b0;
      level_q     <= 1'b0;
    end else begin
      s1_q        <= btn_in;
      s2_q        <= s1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rcnt_q      <= rcnt_d;
      rpt_phase_q <= rpt_phase_d;
      pulse_q     <= pulse_d;
      level_q     <= level_d;
    end
  end

  assign pulse     = pulse_q;
  assign level     = level_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Directed bench for button_debounce_pulse: reset, clean press, bounce, auto-repeat,
// release bounce and reset while held, with hand-computed per-edge expectations.
module tb_button_debounce_pulse;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_in = 1'b0;
  logic       pulse;
  logic       level;
  logic [1:0] fsm_state;

  int total = 0;
  int bad   = 0;

  button_debounce_pulse #(
    .DEB_CYCLES   (4),
    .REPEAT_EN    (1),
    .REPEAT_DELAY (20),
    .REPEAT_PERIOD(8),
    .CNT_W        (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .pulse    (pulse),
    .level    (level),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int edge_no, input logic [31:0] got,
                          input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_no, got, exp);
    end
  endtask

  // Advance one clock edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. Reset held low with button pressed.
    rst    = 1'b0;
    btn_in = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_eq("rst_pulse", i, 32'(pulse), 32'd0);
      check_eq("rst_level", i, 32'(level), 32'd0);
      check_eq("rst_state", i, 32'(fsm_state), 32'd0);
    end
    btn_in = 1'b0;
    rst    = 1'b1;
    for (int i = 1; i <= 4; i++) tick();
    check_eq("idle_state", 0, 32'(fsm_state), 32'd0);

    // 2. Clean press held 12 edges, then release.
    btn_in = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check_eq("press_pulse", i, 32'(pulse), (i == 7) ? 32'd1 : 32'd0);
      check_eq("press_level", i, 32'(level), (i >= 7) ? 32'd1 : 32'd0);
      check_eq("press_state", i, 32'(fsm_state),
               (i < 3) ? 32'd0 : (i < 7) ? 32'd1 : 32'd2);
    end
    btn_in = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_eq("rel_pulse", i, 32'(pulse), 32'd0);
      check_eq("rel_level", i, 32'(level), (i < 7) ? 32'd1 : 32'd0);
      check_eq("rel_state", i, 32'(fsm_state),
               (i < 3) ? 32'd2 : (i < 7) ? 32'd3 : 32'd0);
    end

    // 3. Bounce 1,0,1,0 then low: PRESS_CHK entered twice, rejected both times.
    for (int i = 1; i <= 8; i++) begin
      btn_in = (i == 1 || i == 3) ? 1'b1 : 1'b0;
      tick();
      check_eq("bnc_pulse", i, 32'(pulse), 32'd0);
      check_eq("bnc_level", i, 32'(level), 32'd0);
      check_eq("bnc_state", i, 32'(fsm_state),
               (i == 3 || i == 5) ? 32'd1 : 32'd0);
    end

    // 4. Auto-repeat over 60 held edges.
    btn_in = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      check_eq("rpt_pulse", i, 32'(pulse),
               (i == 7 || i == 27 || i == 35 || i == 43 || i == 51 || i == 59) ? 32'd1 : 32'd0);
    end
    btn_in = 1'b0;
    for (int i = 1; i <= 8; i++) tick();
    check_eq("rpt_rel_level", 8, 32'(level), 32'd0);
    check_eq("rpt_rel_state", 8, 32'(fsm_state), 32'd0);

    // 5. Release bounce: press, 2 edges low, then high again.
    btn_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_eq("rb_press_pulse", i, 32'(pulse), (i == 7) ? 32'd1 : 32'd0);
    end
    for (int i = 1; i <= 20; i++) begin
      btn_in = (i <= 2) ? 1'b0 : 1'b1;
      tick();
      check_eq("rb_pulse", i, 32'(pulse), 32'd0);
      check_eq("rb_level", i, 32'(level), 32'd1);
      check_eq("rb_state", i, 32'(fsm_state), (i == 3 || i == 4) ? 32'd3 : 32'd2);
    end
    btn_in = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_eq("rb_rel_pulse", i, 32'(pulse), 32'd0);
      check_eq("rb_rel_level", i, 32'(level), (i < 7) ? 32'd1 : 32'd0);
    end

    // 6. Reset while HELD, then a fresh press after release of reset.
    btn_in = 1'b1;
    for (int i = 1; i <= 10; i++) tick();
    check_eq("mid_level_pre", 10, 32'(level), 32'd1);
    rst = 1'b0;
    tick();
    check_eq("mid_rst_pulse", 0, 32'(pulse), 32'd0);
    check_eq("mid_rst_level", 0, 32'(level), 32'd0);
    check_eq("mid_rst_state", 0, 32'(fsm_state), 32'd0);
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_eq("post_rst_pulse", i, 32'(pulse), (i == 7) ? 32'd1 : 32'd0);
      check_eq("post_rst_level", i, 32'(level), (i >= 7) ? 32'd1 : 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
